div: RTL and testbench
======================

Name: div

Overview:
- Sequential 32-bit signed integer divider; the inverse companion of the CPU's Booth multiplier.
- Writes the same HI/LO pair as the multiplier: quotient to lo, remainder to hi.
- Uses the same init/stop control style as the multiplier.
- Implements MIPS DIV semantics with a restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- NBITS, 32, operand/result width; only 32 is supported by the CPU datapath.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- a  input  32  dividend, sampled on the init cycle.
- b  input  32  divisor, sampled on the init cycle.
- init  input  1  start pulse from control unit.
- stop  input  1  abort current operation.
- hi  output  32  remainder.
- lo  output  32  quotient.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when hi/lo have just been written.
- div_zero  output  1  one-cycle pulse, coincident with done, when divisor was 0.

Behaviour:
- Reset (rst low, any time, including mid-operation): state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, internal registers cleared.
- States: IDLE, RUN, FIX.
- IDLE, init=1 and b!=0:
  - Latch |a| into the quotient/shift register and |b| into the divisor register; clear the partial remainder.
  - Latch sign_q = a[31]^b[31] and sign_r = a[31].
  - counter=32, busy=1, go to RUN.
- IDLE, init=1 and b==0:
  - Go to FIX with the zero flag set.
  - Next edge: done=1, div_zero=1, hi/lo unchanged, return to IDLE.
- RUN, each cycle:
  - {R,Q} shifted left 1.
  - If R_shifted >= D, then R = R_shifted - D and Q[0]=1; else Q[0]=0.
  - counter decrements.
  - After the 32nd iteration (counter reaches 0), go to FIX.
- FIX:
  - lo = sign_q ? -Q : Q.
  - hi = sign_r ? -R : R.
  - done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: init sampled at edge 0; iterations on edges 1..32; hi/lo written and done asserted at edge 33. done is visible in the cycle after edge 33, i.e. 34 cycles from init to done visible.
- Arithmetic:
  - Magnitudes are 32-bit unsigned; the partial remainder is 33 bits to hold the shifted value.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0; no trap.
- hi/lo hold their values between operations and are written only in FIX.
- stop=1 in RUN or FIX: return to IDLE next edge, busy=0, no done, hi/lo unchanged.
- stop and init in the same cycle: stop wins; no operation starts.
- init while busy: ignored.
- Back-to-back: init in the same cycle as done is accepted, because the state is IDLE then.

Optional Feature:
- Macro DIV_UNSIGNED_EN.
- When defined: adds input port is_unsigned (1 bit), sampled with init.
  - is_unsigned=1 selects MIPS DIVU: operands used raw, no sign latch, no FIX negation.
  - Latency is unchanged.
- When undefined: the port is absent and every operation is signed.

Decomposition:
- Package div_pkg holds:
  - The state enum (IDLE, RUN, FIX).
  - NBITS and the counter width (6).
  - The ITER_COUNT=32 constant.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: R, Q, D.
  - Outputs: next R, next Q.
  - Instantiated once in the RUN datapath.

Test Plan:
- a=7, b=2, init pulse -> done at edge 33 with lo=0x00000003, hi=0x00000001, div_zero=0; busy high for cycles 1..33.
- a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, no flag.
- Preload hi/lo via 100/7 (lo=14, hi=2), then a=5, b=0 -> done and div_zero pulse one cycle after init; hi=2, lo=14 retained.
- a=100, b=7; stop at cycle 10 -> busy drops, no done for 40 cycles, hi/lo keep prior values.
- Repeat the stop scenario with rst low at cycle 10 instead of stop -> all outputs 0 immediately, asynchronously.
- Then init with a=9, b=3 -> lo=3, hi=0.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, state encodings and sign helper for the sequential divider
package div_pkg;

  localparam int NBITS = 32;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] ITER_COUNT = 6'd32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

  function automatic logic [NBITS-1:0] neg_if(input logic neg, input logic [NBITS-1:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_if.sv
// rtl/div_if.sv - operand/result bundle of the divider; DIV_UNSIGNED_EN adds is_unsigned
interface div_if;
  import div_pkg::*;

  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic             init;
  logic             stop;
  logic [NBITS-1:0] hi;
  logic [NBITS-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
`ifdef DIV_UNSIGNED_EN
  logic             is_unsigned;

  modport master (output a, b, init, stop, is_unsigned,
                  input  hi, lo, busy, done, div_zero);
  modport slave  (input  a, b, init, stop, is_unsigned,
                  output hi, lo, busy, done, div_zero);
`else
  modport master (output a, b, init, stop,
                  input  hi, lo, busy, done, div_zero);
  modport slave  (input  a, b, init, stop,
                  output hi, lo, busy, done, div_zero);
`endif

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step
  import div_pkg::*;
(
  input  logic [NBITS-1:0] r_in,
  input  logic [NBITS-1:0] q_in,
  input  logic [NBITS-1:0] d_in,
  output logic [NBITS-1:0] r_out,
  output logic [NBITS-1:0] q_out
);

  logic [NBITS:0]   r_sh;
  logic [NBITS-1:0] r_sub;

  always_comb begin
    r_sh  = {r_in, q_in[NBITS-1]};
    // only taken when r_sh >= d, so the difference always fits in NBITS bits
    r_sub = r_sh[NBITS-1:0] - d_in;
    if (r_sh >= {1'b0, d_in}) begin
      r_out = r_sub;
      q_out = {q_in[NBITS-2:0], 1'b1};
    end else begin
      r_out = r_sh[NBITS-1:0];
      q_out = {q_in[NBITS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div.sv
// rtl/div.sv - sequential 32-bit MIPS DIV (DIVU when DIV_UNSIGNED_EN), quotient to lo, remainder to hi
module div
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  div_if.slave io
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] r_q, r_d;
  logic [NBITS-1:0] q_q, q_d;
  logic [NBITS-1:0] dv_q, dv_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [NBITS-1:0] hi_q, hi_d;
  logic [NBITS-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             op_unsigned;
  logic [NBITS-1:0] step_r, step_q;

`ifdef DIV_UNSIGNED_EN
  assign op_unsigned = io.is_unsigned;
`else
  assign op_unsigned = 1'b0;
`endif

  div_step u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (dv_q),
    .r_out (step_r),
    .q_out (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    dv_d      = dv_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (io.init && !io.stop) begin
          busy_d = 1'b1;
          if (io.b == '0) begin
            zero_d  = 1'b1;
            state_d = ST_FIX;
          end else begin
            q_d       = neg_if(!op_unsigned && io.a[NBITS-1], io.a);
            dv_d      = neg_if(!op_unsigned && io.b[NBITS-1], io.b);
            r_d       = '0;
            neg_quo_d = !op_unsigned && (io.a[NBITS-1] ^ io.b[NBITS-1]);
            neg_rem_d = !op_unsigned && io.a[NBITS-1];
            zero_d    = 1'b0;
            cnt_d     = ITER_COUNT;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (io.stop) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          r_d   = step_r;
          q_d   = step_q;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        busy_d  = 1'b0;
        zero_d  = 1'b0;
        state_d = ST_IDLE;
        if (!io.stop) begin
          // a zero divisor reports through div_zero and leaves hi/lo untouched
          if (!zero_q) begin
            lo_d = neg_if(neg_quo_q, q_q);
            hi_d = neg_if(neg_rem_q, r_q);
          end
          done_d = 1'b1;
          dz_d   = zero_q;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      dv_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      dv_q      <= dv_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign io.hi       = hi_q;
  assign io.lo       = lo_q;
  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.div_zero = dz_q;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for the sequential divider
module tb_div;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   bcnt;
  logic dz;

  always #5 clk = ~clk;

  div_if ifc ();

  div dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ev_kind: 0 none, 1 stop pulse at cycle ev_cyc, 2 new init pulse (9/3) at cycle ev_cyc
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int ev_cyc,
                        input int ev_kind, output int latency, output int busy_cnt,
                        output logic dz_seen);
    ifc.a    = a;
    ifc.b    = b;
    ifc.init = 1'b1;
    @(posedge clk); #1;
    ifc.init = 1'b0;
    latency  = -1;
    busy_cnt = 0;
    dz_seen  = 1'b0;
    for (int c = 0; c <= 45; c++) begin
      if (ifc.busy) busy_cnt++;
      if (ifc.done) begin
        latency = c;
        dz_seen = ifc.div_zero;
        break;
      end
      ifc.stop = (ev_kind == 1) && (c == ev_cyc);
      ifc.init = (ev_kind == 2) && (c == ev_cyc);
      if (ifc.init) begin
        ifc.a = 32'd9;
        ifc.b = 32'd3;
      end
      @(posedge clk); #1;
      ifc.stop = 1'b0;
      ifc.init = 1'b0;
    end
  endtask

  task automatic expect_result(input string tag, input logic [31:0] lo_e, input logic [31:0] hi_e,
                               input int lat_e, input logic dz_e);
    check_eq({tag, "_lat"}, lat, lat_e);
    check_eq({tag, "_lo"}, ifc.lo, lo_e);
    check_eq({tag, "_hi"}, ifc.hi, hi_e);
    check_eq({tag, "_dz"}, {31'd0, dz}, {31'd0, dz_e});
  endtask

  initial begin
    rst      = 1'b0;
    ifc.a    = '0;
    ifc.b    = '0;
    ifc.init = 1'b0;
    ifc.stop = 1'b0;
`ifdef DIV_UNSIGNED_EN
    ifc.is_unsigned = 1'b0;
`endif
    #12;
    check_eq("rst_hi", ifc.hi, 32'h0);
    check_eq("rst_lo", ifc.lo, 32'h0);
    check_eq("rst_busy", {31'd0, ifc.busy}, 32'd0);
    check_eq("rst_done", {31'd0, ifc.done}, 32'd0);
    check_eq("rst_dz", {31'd0, ifc.div_zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(32'd7, 32'd2, 0, 0, lat, bcnt, dz);
    expect_result("7div2", 32'd3, 32'd1, 33, 1'b0);
    check_eq("7div2_busycycles", bcnt, 33);
    check_eq("7div2_busy_at_done", {31'd0, ifc.busy}, 32'd0);
    @(posedge clk); #1;
    check_eq("7div2_done_pulse", {31'd0, ifc.done}, 32'd0);

    run_op(32'hFFFFFFF9, 32'd2, 0, 0, lat, bcnt, dz);
    expect_result("m7div2", 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);

    run_op(32'h80000000, 32'hFFFFFFFF, 0, 0, lat, bcnt, dz);
    expect_result("mindivm1", 32'h80000000, 32'h0, 33, 1'b0);

    run_op(32'd100, 32'd7, 0, 0, lat, bcnt, dz);
    expect_result("100div7", 32'd14, 32'd2, 33, 1'b0);

    run_op(32'd5, 32'd0, 0, 0, lat, bcnt, dz);
    expect_result("div0", 32'd14, 32'd2, 1, 1'b1);
    @(posedge clk); #1;
    check_eq("div0_pulse", {31'd0, ifc.div_zero}, 32'd0);

    run_op(32'hFFFFFF9C, 32'd7, 0, 0, lat, bcnt, dz);
    expect_result("m100div7", 32'hFFFFFFF2, 32'hFFFFFFFE, 33, 1'b0);

    run_op(32'd100, 32'd7, 10, 1, lat, bcnt, dz);
    check_eq("stop_nodone", lat, -1);
    check_eq("stop_busycycles", bcnt, 11);
    check_eq("stop_lo", ifc.lo, 32'hFFFFFFF2);
    check_eq("stop_hi", ifc.hi, 32'hFFFFFFFE);

    run_op(32'd100, 32'd7, 5, 2, lat, bcnt, dz);
    expect_result("init_busy", 32'd14, 32'd2, 33, 1'b0);
    @(posedge clk); #1;

    ifc.a    = 32'd9;
    ifc.b    = 32'd3;
    ifc.init = 1'b1;
    ifc.stop = 1'b1;
    @(posedge clk); #1;
    ifc.init = 1'b0;
    ifc.stop = 1'b0;
    check_eq("stopinit_busy", {31'd0, ifc.busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("stopinit_lo", ifc.lo, 32'd14);

    run_op(32'd100, 32'd7, 10, 0, lat, bcnt, dz);
    ifc.a    = 32'd100;
    ifc.b    = 32'd7;
    ifc.init = 1'b1;
    @(posedge clk); #1;
    ifc.init = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_hi", ifc.hi, 32'h0);
    check_eq("arst_lo", ifc.lo, 32'h0);
    check_eq("arst_busy", {31'd0, ifc.busy}, 32'd0);
    check_eq("arst_done", {31'd0, ifc.done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(32'd9, 32'd3, 0, 0, lat, bcnt, dz);
    expect_result("9div3", 32'd3, 32'd0, 33, 1'b0);
    run_op(32'hFFFFFFF9, 32'hFFFFFFFE, 0, 0, lat, bcnt, dz);
    expect_result("b2b_m7divm2", 32'd3, 32'hFFFFFFFF, 33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
